// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_port_arbiter.
// master = the arbiter's view; slave = the surrounding core/memory environment.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvld;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic [31:0] d_addr;
    logic        d_wen;
    logic [31:0] d_wdata;
    logic [3:0]  d_strobe;
    logic        d_gnt;
    logic        d_rvld;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        RRdy;
    logic [31:0] RAddr;
    logic [31:0] RWData;
    logic        RWEn;
    logic [3:0]  RWStrobe;
    logic        RVld;
    logic [31:0] RData;

    modport master (
        input  i_req, i_addr, d_req, d_addr, d_wen, d_wdata, d_strobe, RVld, RData,
        output i_gnt, i_rvld, i_rdata, i_err, d_gnt, d_rvld, d_rdata, d_err,
        output RRdy, RAddr, RWData, RWEn, RWStrobe
    );

    modport slave (
        output i_req, i_addr, d_req, d_addr, d_wen, d_wdata, d_strobe, RVld, RData,
        input  i_gnt, i_rvld, i_rdata, i_err, d_gnt, d_rvld, d_rdata, d_err,
        input  RRdy, RAddr, RWData, RWEn, RWStrobe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between the fetch (I) and load/store (D) requesters,
// with a watchdog that aborts a transaction whose response never arrives.
module mem_port_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 16,
    parameter int RECOVER   = 2
) (
    input  logic               clk,
    input  logic               rstn,
    mem_port_arbiter_if.master bus,
    output logic               busy,
    output logic               owner
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RECOVER} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rec_q, rec_d;
    logic        rrdy_q, rrdy_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] rwdata_q, rwdata_d;
    logic        rwen_q, rwen_d;
    logic [3:0]  rwstrobe_q, rwstrobe_d;
    logic        is_wr_q, is_wr_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        rvld_q, rvld_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic any_req;
    logic win;
    logic timeout_hit;
    logic rec_done;

    assign any_req = bus.i_req | bus.d_req;
    // Tie-break: fixed D priority, or whichever side did not own the port last.
    assign win = (bus.i_req & bus.d_req) ? ((PRIO_MODE != 0) ? 1'b1 : ~last_owner_q) : bus.d_req;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 16'(TIMEOUT - 1));
    assign rec_done    = (rec_q == 16'(RECOVER - 1));

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rec_q        <= '0;
            rrdy_q       <= 1'b0;
            raddr_q      <= '0;
            rwdata_q     <= '0;
            rwen_q       <= 1'b0;
            rwstrobe_q   <= '0;
            is_wr_q      <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rvld_q       <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rec_q        <= rec_d;
            rrdy_q       <= rrdy_d;
            raddr_q      <= raddr_d;
            rwdata_q     <= rwdata_d;
            rwen_q       <= rwen_d;
            rwstrobe_q   <= rwstrobe_d;
            is_wr_q      <= is_wr_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rvld_q       <= rvld_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_req) state_d = ST_BUSY;
            ST_BUSY: begin
                if (bus.RVld)       state_d = ST_IDLE;
                else if (timeout_hit) state_d = ST_RECOVER;
            end
            ST_RECOVER: if (rec_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = '0;
        rec_d        = '0;
        rrdy_d       = rrdy_q;
        raddr_d      = raddr_q;
        rwdata_d     = rwdata_q;
        rwen_d       = 1'b0;
        rwstrobe_d   = rwstrobe_q;
        is_wr_d      = is_wr_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rvld_d       = 1'b0;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    raddr_d      = win ? bus.d_addr : bus.i_addr;
                    rwdata_d     = win ? bus.d_wdata : 32'h0;
                    rwstrobe_d   = win ? bus.d_strobe : 4'h0;
                    rwen_d       = win & bus.d_wen;
                    is_wr_d      = win & bus.d_wen;
                    rrdy_d       = 1'b1;
                    owner_d      = win;
                    last_owner_d = win;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (bus.RVld) begin
                    rvld_d  = 1'b1;
                    rdata_d = is_wr_q ? 32'h0 : bus.RData;
                    rrdy_d  = 1'b0;
                end else if (timeout_hit) begin
                    rvld_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    rrdy_d  = 1'b0;
                end
            end
            ST_RECOVER: rec_d = rec_q + 16'd1;
            default: ;
        endcase
    end

    always_comb begin
        bus.i_gnt    = (state_q == ST_IDLE) & any_req & ~win;
        bus.d_gnt    = (state_q == ST_IDLE) & any_req & win;
        bus.i_rvld   = rvld_q & ~owner_q;
        bus.d_rvld   = rvld_q & owner_q;
        bus.i_err    = rvld_q & err_q & ~owner_q;
        bus.d_err    = rvld_q & err_q & owner_q;
        bus.i_rdata  = rdata_q;
        bus.d_rdata  = rdata_q;
        bus.RRdy     = rrdy_q;
        bus.RAddr    = raddr_q;
        bus.RWData   = rwdata_q;
        bus.RWEn     = rwen_q;
        bus.RWStrobe = rwstrobe_q;
        busy         = (state_q != ST_IDLE);
        owner        = owner_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin arbiter on a modelled memory (registered or fixed response),
// plus a D-priority instance on a fixed-response port.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if bus0();
    mem_port_arbiter_if bus1();
    logic busy0, owner0, busy1, owner1;

    mem_port_arbiter #(.PRIO_MODE(0), .TIMEOUT(16), .RECOVER(2)) dut0 (
        .clk(clk), .rstn(rstn), .bus(bus0), .busy(busy0), .owner(owner0));
    mem_port_arbiter #(.PRIO_MODE(1), .TIMEOUT(16), .RECOVER(2)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1), .busy(busy1), .owner(owner1));

    // Memory model for dut0: registered one-shot response, or RVld tied high.
    logic [31:0] mem [0:255];
    logic        fixed_mode = 1'b0;
    logic        mute = 1'b0;
    logic        mem_rvld;
    logic [31:0] mem_rdata;
    logic [7:0]  idx;
    int          rwen_cycles = 0;

    assign idx = bus0.RAddr[7:0];
    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            mem_rvld  <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            if (bus0.RRdy && bus0.RWEn)
                for (int b = 0; b < 4; b++)
                    if (bus0.RWStrobe[b]) mem[idx][8*b +: 8] <= bus0.RWData[8*b +: 8];
            mem_rvld  <= bus0.RRdy & ~mem_rvld & ~mute;
            mem_rdata <= mem[idx];
        end
    end
    assign bus0.RVld  = fixed_mode ? 1'b1 : mem_rvld;
    assign bus0.RData = fixed_mode ? mem[idx] : mem_rdata;
    assign bus1.RVld  = 1'b1;
    assign bus1.RData = {24'h0, bus1.RAddr[7:0]};

    always @(negedge clk) if (bus0.RWEn) rwen_cycles++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One dut0 transaction; lat counts cycles from the grant edge to the first rvld cycle.
    task automatic txn(input logic is_d, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] strobe,
                       output int lat, output logic [31:0] rdata, output logic err);
        int g = -1;
        int r = -1;
        rdata = 32'h0;
        err   = 1'b0;
        @(posedge clk); #1;
        if (is_d) begin
            bus0.d_req = 1'b1; bus0.d_addr = addr; bus0.d_wen = wen;
            bus0.d_wdata = wdata; bus0.d_strobe = strobe;
        end else begin
            bus0.i_req = 1'b1; bus0.i_addr = addr;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (is_d ? bus0.d_gnt : bus0.i_gnt) begin g = cyc; break; end
        end
        check("gnt_seen", 32'(g >= 0), 32'd1);
        @(posedge clk); #1;
        bus0.i_req = 1'b0; bus0.d_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (is_d ? bus0.d_rvld : bus0.i_rvld) begin
                r = cyc;
                rdata = is_d ? bus0.d_rdata : bus0.i_rdata;
                err   = is_d ? bus0.d_err : bus0.i_err;
                break;
            end
        end
        check("rvld_seen", 32'(r >= 0), 32'd1);
        lat = r - (g + 1);
        $display("txn %s addr=%h wen=%0d lat=%0d rdata=%h err=%0d",
                 is_d ? "D" : "I", addr, wen, lat, rdata, err);
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          ng, nd, ni, seen, rc;

    initial begin
        bus0.i_req = 0; bus0.i_addr = 0; bus0.d_req = 0; bus0.d_addr = 0;
        bus0.d_wen = 0; bus0.d_wdata = 0; bus0.d_strobe = 0;
        bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_addr = 0;
        bus1.d_wen = 0; bus1.d_wdata = 0; bus1.d_strobe = 0;
        for (int a = 0; a < 256; a++) mem[a] = 32'hA500_0000 | 32'(a);
        mem[8'h10] = 32'h00A0_0513;
        mem[8'h20] = 32'h1122_3344;
        mem[8'h00] = 32'h0000_1111; mem[8'h01] = 32'h0000_2222;
        mem[8'h02] = 32'h0000_3333; mem[8'h03] = 32'h0000_4444;
        do_reset();

        @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_rrdy", 32'(bus0.RRdy), 32'd0);
        check("rst_raddr", bus0.RAddr, 32'h0);
        check("rst_owner", 32'(owner0), 32'd0);
        check("rst_rvld", 32'({bus0.i_rvld, bus0.d_rvld}), 32'd0);

        // Registered-memory fetch
        txn(1'b0, 32'h10, 1'b0, 32'h0, 4'h0, lat, rd, er);
        check("t1_lat", 32'(lat), 32'd2);
        check("t1_rdata", rd, 32'h00A0_0513);
        check("t1_err", 32'(er), 32'd0);

        // Partial-strobe write
        rwen_cycles = 0;
        txn(1'b1, 32'h20, 1'b1, 32'hDEADBEEF, 4'b0011, lat, rd, er);
        check("t2_rwen_width", 32'(rwen_cycles), 32'd1);
        check("t2_mem", mem[8'h20], 32'h1122_BEEF);
        check("t2_rdata", rd, 32'h0);
        check("t2_owner", 32'(owner0), 32'd1);

        // Watchdog abort then recovery
        mute = 1'b1;
        txn(1'b1, 32'h30, 1'b0, 32'h0, 4'h0, lat, rd, er);
        check("t4_lat", 32'(lat), 32'd16);
        check("t4_err", 32'(er), 32'd1);
        check("t4_rdata", rd, 32'h0);
        rc = busy0 ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy0) rc++; else break;
        end
        check("t4_recover_cycles", 32'(rc), 32'd2);
        mute = 1'b0;
        txn(1'b0, 32'h10, 1'b0, 32'h0, 4'h0, lat, rd, er);
        check("t4_next_rdata", rd, 32'h00A0_0513);
        check("t4_next_err", 32'(er), 32'd0);

        // Reset while BUSY
        @(posedge clk); #1;
        bus0.i_req = 1'b1; bus0.i_addr = 32'h10;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus0.i_gnt) begin seen = 1; break; end
        end
        check("t5_gnt_seen", 32'(seen), 32'd1);
        @(posedge clk); #1 bus0.i_req = 1'b0;
        #1 rstn = 1'b1;
        #1;
        check("t5_rrdy", 32'(bus0.RRdy), 32'd0);
        check("t5_busy", 32'(busy0), 32'd0);
        check("t5_raddr", bus0.RAddr, 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus0.i_rvld) seen++;
        end
        check("t5_no_rvld", 32'(seen), 32'd0);
        txn(1'b0, 32'h10, 1'b0, 32'h0, 4'h0, lat, rd, er);
        check("t5_after_rdata", rd, 32'h00A0_0513);
        check("t5_after_lat", 32'(lat), 32'd2);

        // Round-robin under continuous contention, from a fresh reset
        do_reset();
        @(posedge clk); #1;
        bus0.i_req = 1'b1; bus0.i_addr = 32'h10;
        bus0.d_req = 1'b1; bus0.d_addr = 32'h40; bus0.d_wen = 1'b0;
        ng = 0;
        for (int k = 0; k < 200 && ng < 8; k++) begin
            @(negedge clk);
            if (bus0.i_gnt || bus0.d_gnt) begin
                check($sformatf("t3_owner%0d", ng), 32'(bus0.d_gnt), 32'(ng % 2));
                $display("txn grant %0d owner=%s", ng, bus0.d_gnt ? "D" : "I");
                ng++;
            end
        end
        check("t3_grant_count", 32'(ng), 32'd8);
        @(posedge clk); #1;
        bus0.i_req = 1'b0; bus0.d_req = 1'b0;
        repeat (6) @(posedge clk);

        // D priority instance: I never granted while D requests
        #1;
        bus1.i_req = 1'b1; bus1.i_addr = 32'h5;
        bus1.d_req = 1'b1; bus1.d_addr = 32'h7;
        nd = 0; ni = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus1.d_gnt) nd++;
            if (bus1.i_gnt) ni++;
        end
        $display("txn prio d_grants=%0d i_grants=%0d", nd, ni);
        check("t3p_i_gnt", 32'(ni), 32'd0);
        check("t3p_d_many", 32'(nd >= 8), 32'd1);
        check("t3p_owner", 32'(owner1), 32'd1);
        @(posedge clk); #1;
        bus1.i_req = 1'b0; bus1.d_req = 1'b0;
        repeat (3) @(posedge clk);

        // Fixed-response memory, consecutive fetches
        fixed_mode = 1'b1;
        for (int a = 0; a < 4; a++) begin
            txn(1'b0, 32'(a), 1'b0, 32'h0, 4'h0, lat, rd, er);
            check($sformatf("t6_lat%0d", a), 32'(lat), 32'd1);
            check($sformatf("t6_rdata%0d", a), rd, 32'h0000_1111 * 32'(a + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
